// File: rtl/video_src_fader.sv
// Selects the noise or core RGB source for the VGA DAC, switching only at frame
// boundaries via fade-out / black hold / fade-in; colour outputs lag inputs by one pclk.
module video_src_fader #(
   parameter int FADE_SHIFT   = 3,
   parameter int BLACK_FRAMES = 4
) (
   input  logic       pclk,
   input  logic       reset_n,
   input  logic       vs_in,
   input  logic [5:0] r0,
   input  logic [5:0] g0,
   input  logic [5:0] b0,
   input  logic [5:0] r1,
   input  logic [5:0] g1,
   input  logic [5:0] b1,
   input  logic       sel_req,
   output logic       sel_ack,
   output logic       busy,
   output logic       white_noise,
   output logic [5:0] r,
   output logic [5:0] g,
   output logic [5:0] b
);

   localparam int LW = FADE_SHIFT + 1;
   localparam int PW = 6 + LW;
   localparam logic [LW-1:0] FULL = LW'(1 << FADE_SHIFT);
   localparam logic [LW-1:0] ONE  = LW'(1);

   typedef enum logic [1:0] {SHOW, FADE_OUT, BLACK, FADE_IN} state_t;

   state_t          r_state;
   logic            r_cur_sel;
   logic [LW-1:0]   r_level;
   logic [3:0]      r_blk_cnt;
   logic            r_vs_d;
   logic [5:0]      r_red, r_grn, r_blu;
   logic            r_white_noise;

   state_t          w_state_nxt;
   logic            w_sel_nxt;
   logic [LW-1:0]   w_level_nxt;
   logic [3:0]      w_blk_nxt;
   logic            w_tick;
   logic [5:0]      w_src_r, w_src_g, w_src_b;

   function automatic logic [5:0] scale(input logic [5:0] c, input logic [LW-1:0] lv);
      logic [PW-1:0] p;
      p = PW'(c) * PW'(lv);
      return p[FADE_SHIFT +: 6];
   endfunction

   assign w_tick = vs_in & ~r_vs_d;

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_cur_sel;
      w_level_nxt = r_level;
      w_blk_nxt   = r_blk_cnt;
      case (r_state)
         SHOW: begin
            w_level_nxt = FULL;
            if (sel_req != r_cur_sel)
               w_state_nxt = FADE_OUT;
         end
         FADE_OUT: begin
            if (w_tick) begin
               if (r_level <= ONE) begin
                  w_level_nxt = '0;
                  w_blk_nxt   = 4'(BLACK_FRAMES);
                  w_state_nxt = BLACK;
               end else begin
                  w_level_nxt = r_level - ONE;
               end
            end
         end
         BLACK: begin
            w_level_nxt = '0;
            if (w_tick) begin
               if (r_blk_cnt <= 4'd1) begin
                  w_blk_nxt   = '0;
                  w_sel_nxt   = sel_req;
                  w_state_nxt = FADE_IN;
               end else begin
                  w_blk_nxt = r_blk_cnt - 4'd1;
               end
            end
         end
         FADE_IN: begin
            // A new request reverses the fade from wherever the level currently is.
            if (sel_req != r_cur_sel) begin
               w_state_nxt = FADE_OUT;
            end else if (w_tick) begin
               if (r_level >= FULL - ONE) begin
                  w_level_nxt = FULL;
                  w_state_nxt = SHOW;
               end else begin
                  w_level_nxt = r_level + ONE;
               end
            end
         end
         default: w_state_nxt = SHOW;
      endcase
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= SHOW;
         r_cur_sel <= 1'b0;
         r_level   <= FULL;
         r_blk_cnt <= '0;
         r_vs_d    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cur_sel <= w_sel_nxt;
         r_level   <= w_level_nxt;
         r_blk_cnt <= w_blk_nxt;
         r_vs_d    <= vs_in;
      end
   end

   assign w_src_r = r_cur_sel ? r1 : r0;
   assign w_src_g = r_cur_sel ? g1 : g0;
   assign w_src_b = r_cur_sel ? b1 : b0;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_red         <= '0;
         r_grn         <= '0;
         r_blu         <= '0;
         r_white_noise <= 1'b1;
      end else begin
         r_red         <= scale(w_src_r, r_level);
         r_grn         <= scale(w_src_g, r_level);
         r_blu         <= scale(w_src_b, r_level);
         // Computed from next-state values so the enable tracks the state without lag.
         r_white_noise <= ~w_sel_nxt & (w_state_nxt != BLACK);
      end
   end

   assign r           = r_red;
   assign g           = r_grn;
   assign b           = r_blu;
   assign sel_ack     = r_cur_sel;
   assign busy        = (r_state != SHOW);
   assign white_noise = r_white_noise;

endmodule
